// File: rtl/hamming_pkg.sv
// hamming_pkg: flit/byte types and the Hamming(7,4) encoder shared by the
// flit encoder and the downstream decoder.
package hamming_pkg;

    typedef struct packed {
        logic [3:0] dest;
        logic [6:0] cw;
    } flit_t;

    typedef struct packed {
        logic [3:0] dest;
        logic [3:0] payload;
    } src_byte_t;

    // Codeword bit index i carries Hamming position i+1
    localparam int P1_IDX = 0;
    localparam int P2_IDX = 1;
    localparam int D0_IDX = 2;
    localparam int P4_IDX = 3;
    localparam int D1_IDX = 4;
    localparam int D2_IDX = 5;
    localparam int D3_IDX = 6;

    function automatic logic [6:0] hamming74_encode(input logic [3:0] d);
        logic [6:0] cw;
        cw         = '0;
        cw[D0_IDX] = d[0];
        cw[D1_IDX] = d[1];
        cw[D2_IDX] = d[2];
        cw[D3_IDX] = d[3];
        cw[P1_IDX] = d[0] ^ d[1] ^ d[3];
        cw[P2_IDX] = d[0] ^ d[2] ^ d[3];
        cw[P4_IDX] = d[1] ^ d[2] ^ d[3];
        return cw;
    endfunction

endpackage

// File: rtl/hamming_flit_encoder_fifo.sv
// flit_fifo: power-of-two circular buffer; an extra pointer MSB separates
// full from empty.
module flit_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [W-1:0]           din_i,
    input  logic                   pop_i,
    output logic [W-1:0]           dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/hamming_flit_encoder.sv
// hamming_flit_encoder: encodes payload nibbles at write time into a FIFO
// drained through a registered head. HAMMING_ERR_INJECT_EN adds error injection.
module hamming_flit_encoder
    import hamming_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
`ifdef HAMMING_ERR_INJECT_EN
    input  logic                   err_inj_en,
    input  logic [2:0]             err_inj_bit,
    input  logic                   err_inj_once,
`endif
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [10:0]            out_flit,
    output logic [CNT_W-1:0]       flit_count,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int            LW      = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] MAX_LVL = LW'(DEPTH + 1);

    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    flit_t            out_flit_q, out_flit_d;
    logic [CNT_W-1:0] flit_count_q, flit_count_d;

    src_byte_t   src;
    flit_t       wr_flit;
    flit_t       fifo_dout;
    logic [6:0]  inj_mask;
    logic        push, out_pop, load;
    logic        fifo_full, fifo_empty;
    logic [LW-1:0] fifo_cnt, nxt_level;

    assign src     = in_data;
    assign push    = in_valid && in_ready_q;
    assign out_pop = out_valid_q && out_ready;
    // Head register refills whenever it is empty or being consumed this edge
    assign load    = (!out_valid_q || out_pop) && !fifo_empty;

    assign wr_flit.dest = src.dest;
    assign wr_flit.cw   = hamming74_encode(src.payload) ^ inj_mask;

`ifdef HAMMING_ERR_INJECT_EN
    logic inj_spent_q, inj_spent_d;

    always_comb begin
        inj_mask    = '0;
        inj_spent_d = inj_spent_q;
        if (err_inj_en && !inj_spent_q && err_inj_bit != 3'd7)
            inj_mask[err_inj_bit] = 1'b1;
        if (!err_inj_en)
            inj_spent_d = 1'b0;
        else if (push && err_inj_once)
            inj_spent_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) inj_spent_q <= 1'b0;
        else       inj_spent_q <= inj_spent_d;
    end
`else
    assign inj_mask = '0;
`endif

    flit_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(flit_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push && !fifo_full),
        .din_i   (wr_flit),
        .pop_i   (load),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_cnt)
    );

    always_comb begin
        out_valid_d  = out_valid_q;
        out_flit_d   = out_flit_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_flit_d  = fifo_dout;
        end else if (out_pop) begin
            out_valid_d = 1'b0;
        end
        flit_count_d = flit_count_q + CNT_W'(out_pop);
        nxt_level    = fifo_cnt + LW'(out_valid_q) + LW'(push) - LW'(out_pop);
        in_ready_d   = (nxt_level != MAX_LVL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_flit_q   <= '0;
            flit_count_q <= '0;
        end else begin
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_flit_q   <= out_flit_d;
            flit_count_q <= flit_count_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_flit   = out_flit_q;
    assign flit_count = flit_count_q;
    assign fifo_level = fifo_cnt + LW'(out_valid_q);

endmodule
